intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Interrupt controller on the requesting side of the CPU control unit's INTR/INT_TAKEN interface.
//  Synchronises N external IRQ lines and latches rising edges as pending bits.
//  Applies a per-source mask and the CSR global MIE bit, then presents one prioritised request on INTR.
//  Holds INTR and CAUSE stable until the control unit acknowledges with INT_TAKEN.
// PARAMETERS
//  N_SRC        4   number of interrupt sources (1..16)
//  SYNC_STAGES  2   flip-flop synchroniser depth per IRQ line (>=2)
// PORTS
//  CLK        in   1                 system clock, all logic on posedge
//  RST        in   1                 synchronous, active-high reset
//  IRQ_IN     in   N_SRC             asynchronous interrupt lines, rising-edge sensitive
//  MIE        in   1                 global interrupt enable from CSR (mstatus.MIE)
//  MASK_WE    in   1                 write strobe for the mask register
//  MASK_WD    in   N_SRC             mask write data, 1 = source enabled
//  INT_TAKEN  in   1                 one-cycle acknowledge from the control unit's interrupt state
//  INTR       out  1                 interrupt request to the control unit
//  CAUSE      out  $clog2(N_SRC)     index of the source being requested/serviced
//  PENDING    out  N_SRC             raw pending bits (before masking), for CSR/MMIO readback
//  MASK       out  N_SRC             current mask register
// BEHAVIOUR
//  Reset:
//   - All registers clear on the next posedge while RST=1: sync chains, pending, mask, CAUSE all 0.
//   - State returns to ST_IDLE and INTR=0.
//   - Reset mid-request drops INTR at the next edge; the pending bit is lost.
//  Edge capture:
//   - IRQ_IN[i] passes through SYNC_STAGES flops, then a 1-cycle-delayed copy is kept.
//   - A rising edge sets pending[i]; IRQ_IN to pending latency is SYNC_STAGES+1 cycles.
//   - A held-high line sets pending only once.
//  Mask:
//   - MASK_WE loads MASK_WD at the posedge; the new value takes effect the following cycle.
//   - Masking does not clear pending bits.
//  Eligible set = pending & mask; requests are gated by MIE.
//  Priority: lowest index wins (fixed priority).
//  FSM (encoded as a registered state):
//   - ST_IDLE: INTR=0.
//     If MIE and eligible!=0: latch the winner index into CAUSE, go to ST_REQ.
//   - ST_REQ: INTR=1; CAUSE frozen even if a higher-priority source arrives.
//     If INT_TAKEN: clear pending[CAUSE], go to ST_HOLD.
//     Else if MIE=0 or mask[CAUSE]=0: withdraw to ST_IDLE with INTR=0 and pending kept.
//     INT_TAKEN has priority over withdrawal in the same cycle.
//   - ST_HOLD: INTR=0 for exactly 1 cycle (covers the CU returning to fetch), then ST_IDLE.
//   - Illegal encoding: go to ST_IDLE.
//  INTR is a registered output (state decode); it is never combinational from IRQ_IN.
//  INT_TAKEN seen outside ST_REQ is ignored; no pending bit changes.
//  Simultaneous set and clear of pending[CAUSE]: set wins, so the new edge is retained.
//  CAUSE holds its last value in ST_IDLE/ST_HOLD; software reads it after the trap.
//  Back-to-back: a second eligible source is requested no earlier than 2 cycles after INT_TAKEN (HOLD, then IDLE).
// STRUCTURE
//  Package intr_pkg:
//   - typedef enum logic[1:0] {ST_IDLE, ST_REQ, ST_HOLD} intr_state_t
//   - localparam MAX_SRC = 16
//  Sub-module irq_edge_sync: SYNC_STAGES-deep synchroniser plus rising-edge pulse, one instance per source
//   (generate loop).
//  Top level: pending/mask registers, priority encoder (function), FSM.
// TESTING
//  1. Reset: RST=1 for 2 cycles with IRQ_IN=4'hF -> INTR=0, PENDING=0, MASK=0, CAUSE=0.
//  2. Single IRQ: MASK=4'hF, MIE=1, pulse IRQ_IN[2] -> PENDING[2]=1 after 3 cycles.
//     One cycle later INTR=1 with CAUSE=2. INT_TAKEN pulse -> INTR=0, PENDING=0.
//  3. Priority: IRQ_IN[3] and IRQ_IN[1] rise together -> CAUSE=1 first.
//     After INT_TAKEN plus 2 cycles, INTR=1 with CAUSE=3.
//  4. Gating: MIE=0 with IRQ_IN[0] rising -> PENDING[0]=1 and INTR stays 0.
//     Set MIE=1 -> INTR=1 next cycle. Drop MIE while in ST_REQ -> INTR=0 and PENDING[0] still 1.
//  5. Mask: MASK=4'b1110, pulse IRQ_IN[0] -> no INTR. Write MASK=4'hF -> INTR=1 with CAUSE=0.
//  6. Edge cases:
//     - Re-edge on IRQ_IN[2] landing in the INT_TAKEN cycle -> PENDING[2] stays 1, re-requested.
//     - IRQ_IN held high -> only one request.
//     - RST asserted in ST_REQ -> INTR=0 next cycle.

Source files
------------

// File: rtl/intr_pkg.sv
// intr_pkg: shared FSM type and source-count limit for the interrupt controller
package intr_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} intr_state_t;

    localparam int MAX_SRC = 16;

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: multi-flop synchroniser for one async IRQ line with rising-edge pulse output
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic irq,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], irq};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched, maskable, fixed-priority interrupt requester for the CU INTR/INT_TAKEN handshake
module intr_ctrl
    import intr_pkg::*;
#(
    parameter  int N_SRC       = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic             MIE,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_WD,
    input  logic             INT_TAKEN,
    output logic             INTR,
    output logic [CW-1:0]    CAUSE,
    output logic [N_SRC-1:0] PENDING,
    output logic [N_SRC-1:0] MASK
);

    intr_state_t      state;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;

    function automatic logic [CW-1:0] first_set(input logic [N_SRC-1:0] v);
        first_set = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (v[i]) first_set = CW'(i);
    endfunction

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .CLK  (CLK),
            .RST  (RST),
            .irq  (IRQ_IN[i]),
            .rise (rise[i])
        );
    end

    assign eligible = PENDING & MASK;
    assign clr      = (state == ST_REQ && INT_TAKEN) ? N_SRC'(1) << CAUSE : '0;
    assign INTR     = (state == ST_REQ);

    // a fresh edge arriving with the acknowledge survives: set is OR'd after clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            PENDING <= '0;
            MASK    <= '0;
            CAUSE   <= '0;
        end else begin
            PENDING <= (PENDING & ~clr) | rise;
            if (MASK_WE) MASK <= MASK_WD;
            case (state)
                ST_IDLE: if (MIE && |eligible) begin
                    CAUSE <= first_set(eligible);
                    state <= ST_REQ;
                end
                ST_REQ:  state <= INT_TAKEN ? ST_HOLD : (!MIE || !MASK[CAUSE]) ? ST_IDLE : ST_REQ;
                ST_HOLD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus random traffic, every cycle compared against a behavioural model
module tb_intr_ctrl;

    localparam int N  = 4;
    localparam int SS = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         MIE = 1'b0;
    logic         MASK_WE = 1'b0;
    logic         INT_TAKEN = 1'b0;
    logic [N-1:0] IRQ_IN = '1;
    logic [N-1:0] MASK_WD = '0;
    logic         INTR;
    logic [1:0]   CAUSE;
    logic [N-1:0] PENDING;
    logic [N-1:0] MASK;

    int n_err = 0;
    int n_chk = 0;

    // model: IRQ sample history (hist[k] = sample k+1 edges ago), pending/mask sets, request status
    logic [N-1:0] hist [0:SS] = '{default: '0};
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_mask = '0;
    int           m_cause = 0;
    bit           m_req = 1'b0;
    bit           m_hold = 1'b0;

    intr_ctrl #(.N_SRC(N), .SYNC_STAGES(SS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IRQ_IN    (IRQ_IN),
        .MIE       (MIE),
        .MASK_WE   (MASK_WE),
        .MASK_WD   (MASK_WD),
        .INT_TAKEN (INT_TAKEN),
        .INTR      (INTR),
        .CAUSE     (CAUSE),
        .PENDING   (PENDING),
        .MASK      (MASK)
    );

    always #5 CLK = ~CLK;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge CLK) begin : model
        logic [N-1:0] rise_m, clr_m, elig_m;
        if (RST) begin
            m_pend = '0; m_mask = '0; m_cause = 0; m_req = 1'b0; m_hold = 1'b0;
            for (int k = 0; k <= SS; k++) hist[k] = '0;
        end else begin
            rise_m = hist[SS-1] & ~hist[SS];
            for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = IRQ_IN;
            clr_m  = (m_req && INT_TAKEN) ? N'(1 << m_cause) : '0;
            elig_m = m_pend & m_mask;
            if (m_req) begin
                if (INT_TAKEN) begin m_req = 1'b0; m_hold = 1'b1; end
                else if (!MIE || !m_mask[m_cause]) m_req = 1'b0;
            end else if (m_hold) m_hold = 1'b0;
            else if (MIE && elig_m != 0) begin
                m_cause = lowest(elig_m);
                m_req   = 1'b1;
            end
            m_pend = (m_pend & ~clr_m) | rise_m;
            if (MASK_WE) m_mask = MASK_WD;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        check("intr", 32'(INTR), 32'(m_req));
        check("cause", 32'(CAUSE), 32'(m_cause));
        check("pending", 32'(PENDING), 32'(m_pend));
        check("mask", 32'(MASK), 32'(m_mask));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic take();
        INT_TAKEN = 1'b1;
        tick();
        INT_TAKEN = 1'b0;
    endtask

    initial begin
        int  req_cnt;
        bit  prev;
        ticks(2);
        check("rst_intr", 32'(INTR), 0);
        check("rst_pend", 32'(PENDING), 0);
        check("rst_mask", 32'(MASK), 0);
        check("rst_cause", 32'(CAUSE), 0);
        RST = 1'b0; IRQ_IN = '0;
        tick();

        // single source
        MASK_WE = 1'b1; MASK_WD = 4'hF; MIE = 1'b1;
        tick();
        MASK_WE = 1'b0; IRQ_IN = 4'b0100;
        tick();
        IRQ_IN = '0;
        ticks(2);
        check("single_pend", 32'(PENDING), 32'h4);
        check("single_nointr", 32'(INTR), 0);
        tick();
        check("single_intr", 32'(INTR), 1);
        check("single_cause", 32'(CAUSE), 2);
        take();
        check("single_ack_intr", 32'(INTR), 0);
        check("single_ack_pend", 32'(PENDING), 0);
        tick();

        // priority and back-to-back spacing
        IRQ_IN = 4'b1010;
        tick();
        IRQ_IN = '0;
        ticks(3);
        check("prio_cause1", 32'(CAUSE), 1);
        take();
        tick();
        check("prio_gap", 32'(INTR), 0);
        tick();
        check("prio_intr3", 32'(INTR), 1);
        check("prio_cause3", 32'(CAUSE), 3);
        take();
        tick();

        // MIE gating and withdrawal
        MIE = 1'b0; IRQ_IN = 4'b0001;
        tick();
        IRQ_IN = '0;
        ticks(4);
        check("gate_pend0", 32'(PENDING[0]), 1);
        check("gate_nointr", 32'(INTR), 0);
        MIE = 1'b1;
        tick();
        check("gate_intr", 32'(INTR), 1);
        MIE = 1'b0;
        tick();
        check("withdraw_intr", 32'(INTR), 0);
        check("withdraw_pend", 32'(PENDING[0]), 1);
        MIE = 1'b1;
        tick();
        take();
        tick();

        // mask gating
        MASK_WE = 1'b1; MASK_WD = 4'b1110;
        tick();
        MASK_WE = 1'b0; IRQ_IN = 4'b0001;
        tick();
        IRQ_IN = '0;
        ticks(4);
        check("mask_nointr", 32'(INTR), 0);
        MASK_WE = 1'b1; MASK_WD = 4'hF;
        tick();
        MASK_WE = 1'b0;
        check("mask_delay", 32'(INTR), 0);
        tick();
        check("mask_intr", 32'(INTR), 1);
        check("mask_cause", 32'(CAUSE), 0);
        take();
        tick();

        // re-edge arriving in the acknowledge cycle
        IRQ_IN = 4'b0100;
        tick();
        IRQ_IN = '0;
        ticks(3);
        IRQ_IN = 4'b0100;
        tick();
        IRQ_IN = '0;
        tick();
        take();
        check("reedge_pend", 32'(PENDING[2]), 1);
        ticks(2);
        check("reedge_intr", 32'(INTR), 1);
        check("reedge_cause", 32'(CAUSE), 2);
        take();
        tick();

        // held-high line requests once
        IRQ_IN = 4'b0001; req_cnt = 0; prev = 1'b0;
        for (int i = 0; i < 14; i++) begin
            INT_TAKEN = INTR;
            if (INTR && !prev) req_cnt++;
            prev = INTR;
            tick();
        end
        INT_TAKEN = 1'b0;
        check("held_once", 32'(req_cnt), 1);
        IRQ_IN = '0;
        ticks(3);

        // reset while requesting
        IRQ_IN = 4'b1000;
        tick();
        IRQ_IN = '0;
        ticks(3);
        check("rstreq_pre", 32'(INTR), 1);
        RST = 1'b1;
        tick();
        check("rstreq_intr", 32'(INTR), 0);
        check("rstreq_pend", 32'(PENDING), 0);
        RST = 1'b0;
        tick();

        // random traffic
        MASK_WE = 1'b1; MASK_WD = 4'hF;
        tick();
        for (int i = 0; i < 800; i++) begin
            IRQ_IN    = IRQ_IN ^ (N'($urandom) & N'($urandom));
            MIE       = ($urandom_range(7) != 0);
            MASK_WE   = ($urandom_range(15) == 0);
            MASK_WD   = N'($urandom);
            INT_TAKEN = ($urandom_range(2) == 0);
            RST       = ($urandom_range(149) == 0);
            tick();
        end
        RST = 1'b0; INT_TAKEN = 1'b0; MASK_WE = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
